// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR distributed-arithmetic LUT loader.
package fir_pkg;

  localparam int LUT_DEPTH  = 2048;
  localparam int GROUP_BITS = 3;
  localparam int SEL_BITS   = 8;
  localparam int COEF_W     = 16;
  localparam int CIN_W      = 19;
  localparam int ADDR_W     = $clog2(LUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/fir_da_sum8.sv
// Combinational masked adder: sums the coefficients whose mask bit is set,
// each sign-extended to the LUT entry width.
module fir_da_sum8
  import fir_pkg::*;
(
  input  logic [7:0][COEF_W-1:0] coefs,
  input  logic [SEL_BITS-1:0]    mask,
  output logic [CIN_W-1:0]       sum
);

  // NOTE: blocking assignments here build one combinational adder chain; each
  // step reads the value the previous iteration just produced.
  always_comb begin
    sum = '0;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) begin
        sum = sum + {{(CIN_W - COEF_W){coefs[b][COEF_W-1]}}, coefs[b]};
      end
    end
  end

endmodule

// File: rtl/fir_da_lut_loader.sv
// Computes and streams the 2048-entry DA LUT into fir_filter, then gates sample valid.
// Optional FIR_LUT_CHECKSUM_EN adds lut_checksum, the sum of all streamed entries.
module fir_da_lut_loader
  import fir_pkg::*;
#(
  parameter int HOLD_CYCLES = 192,
  parameter int NUM_TAPS    = 64
) (
  input  logic              clk_fast,
  input  logic              reset,
  input  logic              coef_wr,
  input  logic [5:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              start,
  input  logic              sample_valid,
  output logic [CIN_W-1:0]  cin,
  output logic [ADDR_W-1:0] caddr,
  output logic              cload,
  output logic              fir_valid_in,
  output logic              busy,
  output logic              done,
`ifdef FIR_LUT_CHECKSUM_EN
  output logic [29:0]       lut_checksum,
`endif
  output logic              wr_err
);

  if (NUM_TAPS != 64) begin : g_bad_num_taps
    $error("fir_da_lut_loader: NUM_TAPS must be 64");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("fir_da_lut_loader: HOLD_CYCLES must be 1..255");
  end

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t                  state;
  logic [COEF_W-1:0]       coef_file [NUM_TAPS];
  logic [ADDR_W:0]         addr_cnt;  // MSB set once every address has been issued
  logic [7:0]              hold_cnt;
  logic [7:0][COEF_W-1:0]  grp_coefs;
  logic [CIN_W-1:0]        entry;

  // NOTE: every element is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      grp_coefs[b] = coef_file[{addr_cnt[ADDR_W-1:SEL_BITS], 3'(b)}];
    end
  end

  fir_da_sum8 u_sum8 (
    .coefs (grp_coefs),
    .mask  (addr_cnt[SEL_BITS-1:0]),
    .sum   (entry)
  );

  // NOTE: the coefficient file must read as zero after reset, so it is built
  // from resettable flops rather than a RAM macro.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_file[k] <= '0;
      end
    end else if (coef_wr && state != LOAD) begin
      coef_file[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      hold_cnt     <= '0;
      cin          <= '0;
      caddr        <= '0;
      cload        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_err       <= 1'b0;
      fir_valid_in <= 1'b0;
    end else begin
      done         <= 1'b0;
      fir_valid_in <= sample_valid && (state == RUN);
      if (coef_wr && state == LOAD) begin
        wr_err <= 1'b1;
      end
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            addr_cnt <= '0;
            hold_cnt <= '0;
          end
        end
        LOAD: begin
          if (addr_cnt[ADDR_W]) begin
            state <= RUN;
            busy  <= 1'b0;
            cload <= 1'b0;
            done  <= 1'b1;
          end else begin
            cin   <= entry;
            caddr <= addr_cnt[ADDR_W-1:0];
            cload <= 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              addr_cnt <= addr_cnt + (ADDR_W + 1)'(1);
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_LUT_CHECKSUM_EN
  // Each address is added on the first cycle it is issued, so once per entry.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      lut_checksum <= '0;
    end else if (start && state != LOAD) begin
      lut_checksum <= '0;
    end else if (state == LOAD && !addr_cnt[ADDR_W] && hold_cnt == '0) begin
      lut_checksum <= lut_checksum + {{(30 - CIN_W){entry[CIN_W-1]}}, entry};
    end
  end
`endif

endmodule

// File: tb/tb_fir_da_lut_loader.sv
// Self-checking bench for fir_da_lut_loader against an arithmetic LUT model.
// Define FIR_LUT_CHECKSUM_EN to also check lut_checksum.
module tb_fir_da_lut_loader;

  localparam int HOLD = 2;
  localparam int NENT = 2048;

  logic               clk_fast = 1'b0;
  logic               reset;
  logic               coef_wr;
  logic [5:0]         coef_addr;
  logic [15:0]        coef_data;
  logic               start;
  logic               sample_valid;
  logic signed [18:0] cin;
  logic [10:0]        caddr;
  logic               cload;
  logic               fir_valid_in;
  logic               busy;
  logic               done;
  logic               wr_err;
`ifdef FIR_LUT_CHECKSUM_EN
  logic signed [29:0] lut_checksum;
`endif

  int checks   = 0;
  int failures = 0;
  int coef_m   [64];
  int obs_cin  [NENT];
  int prev_cin [NENT];

  always #5 clk_fast = ~clk_fast;

  fir_da_lut_loader #(.HOLD_CYCLES(HOLD), .NUM_TAPS(64)) dut (
    .clk_fast     (clk_fast),
    .reset        (reset),
    .coef_wr      (coef_wr),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .start        (start),
    .sample_valid (sample_valid),
    .cin          (cin),
    .caddr        (caddr),
    .cload        (cload),
    .fir_valid_in (fir_valid_in),
    .busy         (busy),
    .done         (done),
`ifdef FIR_LUT_CHECKSUM_EN
    .lut_checksum (lut_checksum),
`endif
    .wr_err       (wr_err)
  );

  // LUT entry from the definition: group selects 8 taps, low byte selects which to add.
  function automatic int model_entry(input int addr);
    int g = addr / 256;
    int a = addr % 256;
    int s = 0;
    for (int b = 0; b < 8; b++) begin
      if (((a >> b) & 1) == 1) s += coef_m[8 * g + b];
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input int addr, input int value);
    coef_wr   = 1'b1;
    coef_addr = 6'(addr);
    coef_data = 16'(value);
    coef_m[addr] = value;
    @(negedge clk_fast);
    coef_wr = 1'b0;
  endtask

  // Pulses start at the current negedge and follows the whole load stream.
  // inj_n >= 0: a coef_wr+start at cycle inj_n and a lone start at cycle 3000.
  // abort_n >= 0: reset is asserted after the compare at cycle abort_n.
  task automatic do_load(input string tag, input int inj_n, input int abort_n,
                         output int errs);
    int ea;
    errs  = 0;
    start = 1'b1;
    @(negedge clk_fast);
    start   = 1'b0;
    coef_wr = 1'b0;
    check({tag, "_busy_t1"}, busy, 1);
    check({tag, "_cload_t1"}, cload, 0);
    for (int n = 0; n < NENT * HOLD; n++) begin
      @(negedge clk_fast);
      coef_wr = 1'b0;
      start   = 1'b0;
      ea = n / HOLD;
      if (n == 0) check({tag, "_fv_drop"}, fir_valid_in, 0);
      if (cload !== 1'b1 || caddr !== 11'(ea) || cin !== 19'(model_entry(ea)) ||
          busy !== 1'b1 || done !== 1'b0 || fir_valid_in !== 1'b0) errs++;
      if (n % HOLD == 0) obs_cin[ea] = cin;
      if (n == abort_n) begin
        reset = 1'b1;
        @(negedge clk_fast);
        check({tag, "_rst_cload"}, cload, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_caddr"}, caddr, 0);
        check({tag, "_rst_cin"}, cin, 0);
        check({tag, "_rst_wr_err"}, wr_err, 0);
        check({tag, "_rst_fv"}, fir_valid_in, 0);
        reset = 1'b0;
        for (int k = 0; k < 64; k++) coef_m[k] = 0;
        return;
      end
      if (inj_n >= 0 && n == inj_n) begin
        coef_wr   = 1'b1;
        coef_addr = 6'($urandom_range(63));
        coef_data = 16'($urandom);
        start     = 1'b1;
      end
      if (inj_n >= 0 && n == 3000) start = 1'b1;
    end
    @(negedge clk_fast);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_cload_end"}, cload, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_caddr_hold"}, caddr, NENT - 1);
    check({tag, "_cin_hold"}, cin, model_entry(NENT - 1));
    check({tag, "_fv_at_done"}, fir_valid_in, 0);
    @(negedge clk_fast);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_fv_run"}, fir_valid_in, 1);
  endtask

  initial begin
    int    errs;
    int    diffs;
    int    prev_sv;
    longint model_sum;

    reset        = 1'b1;
    coef_wr      = 1'b0;
    coef_addr    = '0;
    coef_data    = '0;
    start        = 1'b0;
    sample_valid = 1'b1;
    for (int k = 0; k < 64; k++) coef_m[k] = 0;
    repeat (3) @(negedge clk_fast);
    check("rst_cin", cin, 0);
    check("rst_caddr", caddr, 0);
    check("rst_cload", cload, 0);
    check("rst_fv", fir_valid_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_fast);
    check("idle_fv", fir_valid_in, 0);

    // Test 1: coef[k]=k+1, last write coincides with start.
    for (int k = 0; k < 63; k++) write_coef(k, k + 1);
    coef_wr   = 1'b1;
    coef_addr = 6'd63;
    coef_data = 16'd64;
    coef_m[63] = 64;
    do_load("t1", -1, -1, errs);
    check("t1_stream", errs, 0);
    check("t1_cin_003", obs_cin[3], 3);
    check("t1_cin_0ff", obs_cin[255], 36);
    check("t1_cin_7ff", obs_cin[2047], 484);
    check("t1_wr_err", wr_err, 0);
`ifdef FIR_LUT_CHECKSUM_EN
    model_sum = 0;
    for (int a = 0; a < NENT; a++) model_sum += model_entry(a);
    check("t6_checksum", lut_checksum, model_sum);
`else
    model_sum = 0;
`endif

    // Test 2: extreme coefficients.
    for (int k = 0; k < 64; k++) write_coef(k, -32768);
    do_load("t2n", -1, -1, errs);
    check("t2n_stream", errs, 0);
    check("t2n_cin_0ff", obs_cin[255], -262144);
    check("t2n_cin_001", obs_cin[1], -32768);
    for (int k = 0; k < 64; k++) write_coef(k, 32767);
    do_load("t2p", -1, -1, errs);
    check("t2p_stream", errs, 0);
    check("t2p_cin_7ff", obs_cin[2047], 262136);

    // Test 3: random coefficients; writes and starts during LOAD are ignored.
    for (int k = 0; k < 64; k++) write_coef(k, int'($urandom_range(65535)) - 32768);
    do_load("t3a", 100, -1, errs);
    check("t3a_stream", errs, 0);
    check("t3_wr_err", wr_err, 1);
    for (int a = 0; a < NENT; a++) prev_cin[a] = obs_cin[a];
    do_load("t3b", -1, -1, errs);
    check("t3b_stream", errs, 0);
    diffs = 0;
    for (int a = 0; a < NENT; a++) if (prev_cin[a] != obs_cin[a]) diffs++;
    check("t3_repeat_diffs", diffs, 0);

    // Test 5: random sample_valid in RUN, one-cycle latency.
    prev_sv = 1;
    for (int i = 0; i < 24; i++) begin
      sample_valid = 1'($urandom_range(1));
      @(negedge clk_fast);
      check("t5_fv_rand", fir_valid_in, sample_valid);
      prev_sv = sample_valid;
    end
    sample_valid = 1'b1;
    @(negedge clk_fast);
    check("t5_fv_run", fir_valid_in, 1);

    // Test 4: reset at caddr 0x200, then reload with a cleared file.
    do_load("t4", -1, 1024, errs);
    check("t4_partial_stream", errs, 0);
    repeat (2) @(negedge clk_fast);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_fv", fir_valid_in, 0);
    do_load("t4r", -1, -1, errs);
    check("t4r_stream", errs, 0);
    check("t4r_cin_000", obs_cin[0], 0);
    check("t4r_cin_7ff", obs_cin[2047], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
